// File: rtl/cv_frame_smoother.sv
// cv_frame_smoother
//   Brings the five CV words from the SPI receiver into the i_Clock domain. Each completed
//   frame is captured, run through a per-channel one-pole low-pass filter, and published.
//   The filter uses one shared datapath that handles one channel per cycle. All five results
//   are published together with a one-cycle o_Valid strobe. A watchdog raises o_Stale when
//   frames stop arriving.
// Ports
//   i_Clock, i_Reset_N   main clock; asynchronous active-low reset
//   i_Data0..i_Data4     16-bit CV words; quasi-static while i_Data_Received is high
//   i_Data_Received      asynchronous frame-complete level from the SPI domain
//   o_CV0..o_CV4         filtered CV words, registered
//   o_Valid              one-cycle pulse when o_CV0..4 update
//   o_Stale              no frame within TIMEOUT_CYCLES, or none since reset
module cv_frame_smoother #(
  parameter int SMOOTH_SHIFT   = 3,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_W      = 16
) (
  input  logic        i_Clock,
  input  logic        i_Reset_N,
  input  logic [15:0] i_Data0,
  input  logic [15:0] i_Data1,
  input  logic [15:0] i_Data2,
  input  logic [15:0] i_Data3,
  input  logic [15:0] i_Data4,
  input  logic        i_Data_Received,
  output logic [15:0] o_CV0,
  output logic [15:0] o_CV1,
  output logic [15:0] o_CV2,
  output logic [15:0] o_CV3,
  output logic [15:0] o_CV4,
  output logic        o_Valid,
  output logic        o_Stale
);

  localparam int NUM_CH = 5;
  localparam int AW     = 16 + SMOOTH_SHIFT;
  localparam logic [2:0]           LAST_CH = 3'(NUM_CH - 1);
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_W-1:0] WD_PRE  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FILTER, S_PUBLISH} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  sync_q;   // [1:0] synchroniser, [2] previous synced level
  logic                        evt;
  logic                        pending_q;
  logic                        prime_q;
  logic [2:0]                  ch_q;
  logic [NUM_CH-1:0][15:0]     din;
  logic [NUM_CH-1:0][15:0]     shadow_q;
  logic [NUM_CH-1:0][AW-1:0]   acc_q;
  logic [NUM_CH-1:0][15:0]     cv_q;
  logic [TIMEOUT_W-1:0]        wd_q;
  logic [AW-1:0]               cur_acc, cur_smp, acc_new;

  assign din = {i_Data4, i_Data3, i_Data2, i_Data1, i_Data0};
  assign evt = sync_q[1] & ~sync_q[2];

  // Shared filter datapath. Priming loads the accumulator so the first output equals the
  // sample, with no ramp from zero. In steady state the accumulator holds 2^S * output, so
  // acc - acc/2^S + x is bounded by 2^S * 0xFFFF and cannot overflow AW bits.
  assign cur_acc = acc_q[ch_q];
  assign cur_smp = AW'(shadow_q[ch_q]);
  assign acc_new = prime_q ? (cur_smp << SMOOTH_SHIFT)
                           : (cur_acc - (cur_acc >> SMOOTH_SHIFT) + cur_smp);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (evt || pending_q) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_FILTER;
      S_FILTER:  if (ch_q == LAST_CH) state_d = S_PUBLISH;
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q   <= S_IDLE;
      sync_q    <= '0;
      pending_q <= 1'b0;
      prime_q   <= 1'b0;
      ch_q      <= '0;
      shadow_q  <= '0;
      acc_q     <= '0;
      cv_q      <= '0;
      wd_q      <= '0;
      o_Valid   <= 1'b0;
      o_Stale   <= 1'b1;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], i_Data_Received};
      o_Valid <= (state_q == S_PUBLISH);

      // One outstanding frame is remembered while busy; anything further coalesces into it.
      if (state_q == S_IDLE) pending_q <= 1'b0;
      else if (evt)          pending_q <= 1'b1;

      if (state_q == S_CAPTURE) begin
        shadow_q <= din;
        prime_q  <= o_Stale;
        ch_q     <= '0;
      end else if (state_q == S_FILTER) begin
        acc_q[ch_q] <= acc_new;
        ch_q        <= ch_q + 3'd1;
      end

      if (state_q == S_PUBLISH)
        for (int n = 0; n < NUM_CH; n++) cv_q[n] <= 16'(acc_q[n] >> SMOOTH_SHIFT);

      // Watchdog: CAPTURE takes priority over saturation/terminal.
      if (state_q == S_CAPTURE)  wd_q <= '0;
      else if (wd_q != WD_MAX)   wd_q <= wd_q + 1'b1;

      // Stale rises on the edge where the counter reaches TIMEOUT_CYCLES.
      if (state_q == S_PUBLISH)                               o_Stale <= 1'b0;
      else if (state_q != S_CAPTURE && wd_q >= WD_PRE)        o_Stale <= 1'b1;
    end
  end

  assign o_CV0 = cv_q[0];
  assign o_CV1 = cv_q[1];
  assign o_CV2 = cv_q[2];
  assign o_CV3 = cv_q[3];
  assign o_CV4 = cv_q[4];

endmodule

// File: tb/tb_cv_frame_smoother.sv
module tb_cv_frame_smoother;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic        flag = 1'b0;
  logic [15:0] cv0, cv1, cv2, cv3, cv4;
  logic        vld, stale;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt = 0;
  int dbl = 0;
  int vlast = 0;
  int vprev = 0;
  logic prev_v = 1'b0;

  cv_frame_smoother #(.SMOOTH_SHIFT(3), .TIMEOUT_CYCLES(1000), .TIMEOUT_W(16)) dut (
    .i_Clock(clk), .i_Reset_N(rst_n),
    .i_Data0(d0), .i_Data1(d1), .i_Data2(d2), .i_Data3(d3), .i_Data4(d4),
    .i_Data_Received(flag),
    .o_CV0(cv0), .o_CV1(cv1), .o_CV2(cv2), .o_CV3(cv3), .o_CV4(cv4),
    .o_Valid(vld), .o_Stale(stale)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld) begin
      vcnt  = vcnt + 1;
      vprev = vlast;
      vlast = cyc;
      if (prev_v) dbl = dbl + 1;
    end
    prev_v = vld;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] cvs();
    return {cv0, cv1, cv2, cv3, cv4};
  endfunction

  // Present a frame, wait (bounded) for o_Valid, then drop the flag. lat = edges to o_Valid.
  task automatic frame(input logic [15:0] a, b, c, d, e, output int lat);
    d0 = a; d1 = b; d2 = c; d3 = d; d4 = e;
    flag = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (vld) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("frame_timeout", 80'(vld), 80'(1));
    flag = 1'b0;
    tick(3);
  endtask

  int lat;
  int v0;
  int m_cyc;

  initial begin
    // 1: reset state, then quiet after release
    tick(3);
    check("rst_cv", cvs(), 80'h0);
    check("rst_valid", 80'(vld), 80'(0));
    check("rst_stale", 80'(stale), 80'(1));
    rst_n = 1'b1;
    tick(20);
    check("idle_no_valid", 80'(vcnt), 80'(0));
    check("idle_stale", 80'(stale), 80'(1));

    // 2: first frame primes, outputs equal inputs, latency 10 edges after flag driven
    frame(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'hFFFF, lat);
    check("first_latency", 80'(lat), 80'(10));
    check("first_cv", cvs(), {16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'hFFFF});
    check("first_stale", 80'(stale), 80'(0));
    check("first_one_pulse", 80'(vcnt), 80'(1));

    // 3: ch0 steps to zero -> filtered decay
    frame(16'h0000, 16'h2000, 16'h3000, 16'h4000, 16'hFFFF, lat);
    check("decay1", cvs(), {16'h0E00, 16'h2000, 16'h3000, 16'h4000, 16'hFFFF});
    frame(16'h0000, 16'h2000, 16'h3000, 16'h4000, 16'hFFFF, lat);
    check("decay2", cvs(), {16'h0C40, 16'h2000, 16'h3000, 16'h4000, 16'hFFFF});

    // 4: reset, then full-scale frames never wrap
    rst_n = 1'b0;
    tick(2);
    check("rst2_cv", cvs(), 80'h0);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 20; i++) begin
      frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, lat);
      check("fullscale", cvs(), {5{16'hFFFF}});
    end

    // 5a: flag held high for 100 cycles is one event
    v0 = vcnt;
    flag = 1'b1;
    tick(100);
    flag = 1'b0;
    tick(5);
    check("held_one_valid", 80'(vcnt - v0), 80'(1));

    // 5b: second rise during FILTER queues, third rise while pending is dropped
    v0 = vcnt;
    m_cyc = cyc;
    flag = 1'b1;  tick(2);
    flag = 1'b0;  tick(1);
    flag = 1'b1;  tick(2);
    flag = 1'b0;  tick(1);
    flag = 1'b1;  tick(40);
    check("pend_count", 80'(vcnt - v0), 80'(2));
    check("pend_first_lat", 80'(vprev - m_cyc), 80'(10));
    check("pend_spacing", 80'(vlast - vprev), 80'(8));
    check("pend_cv", cvs(), {5{16'hFFFF}});
    flag = 1'b0;

    // 6: watchdog timeout, hold, then priming frame
    tick(950);
    check("stale_before", 80'(stale), 80'(0));
    tick(30);
    check("stale_after", 80'(stale), 80'(1));
    check("stale_hold_cv", cvs(), {5{16'hFFFF}});
    frame(16'h0000, 16'h1234, 16'h8000, 16'h0001, 16'hABCD, lat);
    check("reprime_cv", cvs(), {16'h0000, 16'h1234, 16'h8000, 16'h0001, 16'hABCD});
    check("reprime_stale", 80'(stale), 80'(0));

    // reset in the middle of FILTER abandons the frame
    v0 = vcnt;
    d0 = 16'h5555; d1 = 16'h6666;
    flag = 1'b1;
    tick(6);
    rst_n = 1'b0;
    #1;
    check("midrst_cv", cvs(), 80'h0);
    check("midrst_valid", 80'(vld), 80'(0));
    check("midrst_stale", 80'(stale), 80'(1));
    flag = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("midrst_no_valid", 80'(vcnt - v0), 80'(0));
    check("no_back_to_back", 80'(dbl), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
